sdr_lane_scheduler: RTL and testbench

//  Shares one bit-serial SDR encoder lane between NREQ requesters using round-robin grants.
//  For each granted word it resets and configures the lane (budget select), holds the word stable,
//  and collects the serial magnitude and sign digits into 8-bit result vectors.
//  It sits between the activation fetch FIFOs and the single sdr_encoder instance in each PE column.
//

---
 rtl/sdr_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/sdr_lane_scheduler.sv | 163 ++++++++++++++++
 tb/tb_sdr_lane_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// Shared types and constants for the SDR encoder lane schedulers.
package sdr_pkg;

    localparam int unsigned SDR_WORD_W = 8;

    localparam logic BUDGET_2 = 1'b0;
    localparam logic BUDGET_3 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        RESULT = 2'd3
    } state_e;

    // Maximum nonzero digit count the encoder may emit for a budget select.
    function automatic int unsigned digit_limit(input logic budget);
        return (budget == BUDGET_3) ? 32'd3 : 32'd2;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx
);

    logic            found;
    logic [IDXW-1:0] idx;

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            idx = IDXW'((32'(ptr) + o) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/sdr_lane_scheduler.sv
// Time-shares one bit-serial SDR encoder lane between NREQ requesters: round-robin grant,
// encoder reset/configuration, and capture of the serial digits into 8-bit result vectors.
module sdr_lane_scheduler
    import sdr_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ENC_LAT = 3,
    parameter int unsigned IDW     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [SDR_WORD_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]            req_budget,
    output logic [NREQ-1:0]            req_ready,
    output logic                       enc_reset,
    output logic                       enc_enable,
    output logic [SDR_WORD_W-1:0]      enc_word,
    output logic                       enc_budget,
    input  logic                       enc_out,
    input  logic                       enc_sign,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [IDW-1:0]             result_id,
    output logic [SDR_WORD_W-1:0]      result_mag,
    output logic [SDR_WORD_W-1:0]      result_sign,
    output logic                       busy
);

    localparam int unsigned CNT_W    = $clog2(ENC_LAT + 8);
    localparam int unsigned CNT_LAST = ENC_LAT + 7;

    state_e                state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SDR_WORD_W-1:0] word_q, word_d;
    logic                  budget_q, budget_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [SDR_WORD_W-1:0] mag_q, mag_d;
    logic [SDR_WORD_W-1:0] sign_q, sign_d;
    logic                  enc_reset_q, enc_reset_d;
    logic                  enc_enable_q, enc_enable_d;
    logic                  result_valid_q, result_valid_d;
    logic                  busy_q, busy_d;

    logic [NREQ-1:0]       grant;
    logic [IDW-1:0]        grant_idx;
    logic [2:0]            dig;
    logic [SDR_WORD_W-1:0] req_word [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_word
        assign req_word[i] = req_data[SDR_WORD_W*i +: SDR_WORD_W];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Digit k arrives when cnt reaches ENC_LAT+k.
    assign dig = 3'(cnt_q - CNT_W'(ENC_LAT));

    // Accept pulse shares the cycle with the grant decision, so it cannot be registered.
    assign req_ready = (state_q == IDLE && !reset) ? grant : '0;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        budget_d = budget_q;
        id_d     = id_q;
        mag_d    = mag_q;
        sign_d   = sign_q;

        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    word_d   = req_word[grant_idx];
                    budget_d = req_budget[grant_idx];
                    id_d     = grant_idx;
                    ptr_d    = IDW'((32'(grant_idx) + 32'd1) % NREQ);
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                mag_d   = '0;
                sign_d  = '0;
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (cnt_q >= CNT_W'(ENC_LAT)) begin
                    mag_d[dig]  = enc_out;
                    sign_d[dig] = enc_sign;
                end
                if (cnt_q == CNT_W'(CNT_LAST)) begin
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESULT: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The lane runs only while streaming; everywhere else it is parked in reset.
        enc_reset_d    = (state_d != STREAM);
        enc_enable_d   = (state_d == STREAM);
        result_valid_d = (state_d == RESULT);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            cnt_q          <= '0;
            word_q         <= '0;
            budget_q       <= BUDGET_2;
            id_q           <= '0;
            mag_q          <= '0;
            sign_q         <= '0;
            enc_reset_q    <= 1'b1;
            enc_enable_q   <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            word_q         <= word_d;
            budget_q       <= budget_d;
            id_q           <= id_d;
            mag_q          <= mag_d;
            sign_q         <= sign_d;
            enc_reset_q    <= enc_reset_d;
            enc_enable_q   <= enc_enable_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign enc_reset    = enc_reset_q;
    assign enc_enable   = enc_enable_q;
    assign enc_word     = word_q;
    assign enc_budget   = budget_q;
    assign result_valid = result_valid_q;
    assign result_id    = id_q;
    assign result_mag   = mag_q;
    assign result_sign  = sign_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sdr_lane_scheduler.sv
// Bench for sdr_lane_scheduler: encoder stub, timeline model with per-cycle compare, directed tests.
`timescale 1ns/1ps
module tb_sdr_lane_scheduler;

    localparam int NREQ    = 4;
    localparam int ENC_LAT = 3;
    localparam int IDW     = 2;
    localparam int LAT     = ENC_LAT + 10;

    localparam logic [7:0] T6_W [8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h55, 8'h55, 8'h37, 8'h37};
    localparam logic       T6_B [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [7:0] T6_M [8] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h50, 8'h54, 8'h48, 8'h49};
    localparam logic [7:0] T6_S [8] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h08, 8'h09};
    localparam int         T2_ORD [5] = '{0, 1, 2, 3, 0};
    localparam logic [3:0] T3_TOG [8] = '{4'hF, 4'h0, 4'hA, 4'h5, 4'hF, 4'h3, 4'hC, 4'h0};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_budget;
    logic [3:0]  req_ready;
    logic        enc_reset, enc_enable, enc_budget;
    logic [7:0]  enc_word;
    logic        enc_out = 1'b0, enc_sign = 1'b0;
    logic        result_valid, result_ready;
    logic [1:0]  result_id;
    logic [7:0]  result_mag, result_sign;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    sdr_lane_scheduler #(.NREQ(NREQ), .ENC_LAT(ENC_LAT), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_budget(req_budget), .req_ready(req_ready),
        .enc_reset(enc_reset), .enc_enable(enc_enable), .enc_word(enc_word), .enc_budget(enc_budget),
        .enc_out(enc_out), .enc_sign(enc_sign),
        .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
        .result_mag(result_mag), .result_sign(result_sign), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Golden SDR: 8-digit non-adjacent form of the signed word, keeping the top 2 or 3 nonzero digits.
    function automatic void golden(input logic [7:0] w, input logic b,
                                   output logic [7:0] mag, output logic [7:0] sgn);
        int v, d, keep;
        logic [7:0] m, s;
        v = int'($signed(w));
        m = '0;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            if (v % 2 != 0) begin
                d = ((v & 3) == 1) ? 1 : -1;
                v = v - d;
                m[3'(i)] = 1'b1;
                s[3'(i)] = (d < 0);
            end
            v = v / 2;
        end
        keep = b ? 3 : 2;
        mag = '0;
        sgn = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[3'(i)] && keep > 0) begin
                mag[3'(i)] = 1'b1;
                sgn[3'(i)] = s[3'(i)];
                keep--;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Encoder stub: digit k appears ENC_LAT+k cycles after reset release.
    int         ecnt = 0;
    logic [7:0] emag, esgn;
    always @(negedge clk) begin
        if (enc_reset || !enc_enable) begin
            ecnt     = 0;
            enc_out  = 1'b0;
            enc_sign = 1'b0;
        end else begin
            golden(enc_word, enc_budget, emag, esgn);
            if (ecnt >= ENC_LAT && ecnt < ENC_LAT + 8) begin
                enc_out  = emag[3'(ecnt - ENC_LAT)];
                enc_sign = esgn[3'(ecnt - ENC_LAT)];
            end else begin
                enc_out  = 1'b0;
                enc_sign = 1'b0;
            end
            ecnt++;
        end
    end

    // Transaction timeline model: grant at t0, LOAD t0+1, STREAM t0+2..t0+LAT-1, result from t0+LAT.
    bit         m_active = 1'b0;
    int         m_ptr = 0, m_t0 = 0, m_id = 0, rel, g, gi;
    logic [7:0] m_word;
    logic       m_budget, found;
    logic [3:0] e_ready;
    logic       e_busy, e_rst, e_en, e_rv;
    logic [7:0] g_mag, g_sgn;
    int         gq_id[$], gq_cyc[$];

    always @(negedge clk) begin
        if (chk_en) begin
            rel     = cyc - m_t0;
            e_ready = '0;
            e_busy  = 1'b0;
            e_rst   = 1'b1;
            e_en    = 1'b0;
            e_rv    = 1'b0;
            found   = 1'b0;
            g       = 0;
            if (!m_active) begin
                for (int o = 0; o < NREQ; o++) begin
                    gi = (m_ptr + o) % NREQ;
                    if (!found && req_valid[2'(gi)]) begin
                        found = 1'b1;
                        g     = gi;
                    end
                end
                if (reset) found = 1'b0;
                if (found) e_ready = 4'(1 << g);
            end else begin
                e_busy = 1'b1;
                if (rel >= 2 && rel <= ENC_LAT + 9) begin
                    e_rst = 1'b0;
                    e_en  = 1'b1;
                end
                if (rel >= LAT) e_rv = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("enc_reset", 32'(enc_reset), 32'(e_rst));
            chk("enc_enable", 32'(enc_enable), 32'(e_en));
            chk("result_valid", 32'(result_valid), 32'(e_rv));
            if (m_active) begin
                chk("enc_word", 32'(enc_word), 32'(m_word));
                chk("enc_budget", 32'(enc_budget), 32'(m_budget));
            end
            if (e_rv) begin
                golden(m_word, m_budget, g_mag, g_sgn);
                chk("result_id", 32'(result_id), 32'(m_id));
                chk("result_mag", 32'(result_mag), 32'(g_mag));
                chk("result_sign", 32'(result_sign), 32'(g_sgn));
                chk("popcount", 32'($countones(result_mag) <= (m_budget ? 3 : 2)), 32'd1);
            end
            if (req_ready != 4'b0) begin
                for (int k = 0; k < NREQ; k++) if (req_ready[2'(k)]) gq_id.push_back(k);
                gq_cyc.push_back(cyc);
            end
            if (reset) begin
                m_active = 1'b0;
                m_ptr    = 0;
            end else if (!m_active) begin
                if (found) begin
                    m_active = 1'b1;
                    m_t0     = cyc;
                    m_id     = g;
                    m_word   = 8'(req_data >> (8 * g));
                    m_budget = req_budget[2'(g)];
                    m_ptr    = (g + 1) % NREQ;
                end
            end else if (e_rv && result_ready) begin
                m_active = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] v, output int gc, output int gg);
        gc = -1;
        gg = -1;
        step();
        req_valid = v;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                gc = cyc;
                for (int k = 0; k < NREQ; k++) if (req_ready[2'(k)]) gg = k;
                break;
            end
        end
        if (gc < 0) timeout("issue_grant");
        step();
        req_valid = 4'b0;
    endtask

    task automatic wait_rv(output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (result_valid) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) timeout("wait_result_valid");
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_idle");
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int gc, gg, c;

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        req_budget   = '0;
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enc_reset", 32'(enc_reset), 32'd1);
        chk("rst_enc_enable", 32'(enc_enable), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_result_mag", 32'(result_mag), 32'd0);
        chk("rst_enc_word", 32'(enc_word), 32'd0);
        chk_en = 1'b1;
        step();
        reset = 1'b0;

        // Test 1: single request, word 0x07, 3-digit budget.
        req_data   = 32'h0000_0007;
        req_budget = 4'b0001;
        step();
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        gc = cyc;
        step();
        req_valid = 4'b0;
        wait_rv(c);
        chk("t1_latency", 32'(c - gc), 32'(LAT));
        chk("t1_id", 32'(result_id), 32'd0);
        chk("t1_mag", 32'(result_mag), 32'h09);
        chk("t1_sign", 32'(result_sign), 32'h01);
        wait_idle();

        // Test 2: all requesters valid, back-to-back round robin.
        do_reset();
        req_data   = 32'h37FF_5507;
        req_budget = 4'b1010;
        gq_id.delete();
        gq_cyc.delete();
        step();
        req_valid = 4'hF;
        for (int i = 0; i < 200 && gq_id.size() < 5; i++) @(negedge clk);
        step();
        req_valid = 4'b0;
        if (gq_id.size() < 5) begin
            timeout("t2_grants");
        end else begin
            for (int i = 0; i < 5; i++) chk("t2_order", 32'(gq_id[i]), 32'(T2_ORD[i]));
            for (int i = 1; i < 5; i++) chk("t2_gap", 32'(gq_cyc[i] - gq_cyc[i-1]), 32'(ENC_LAT + 11));
        end
        wait_idle();

        // Test 3: pointer wrap onto requester 2, req_valid noise during STREAM.
        req_data   = 32'h1122_3344;
        req_budget = 4'b0100;
        issue(4'b0100, gc, gg);
        chk("t3_first_grant", 32'(gg), 32'd2);
        wait_idle();
        issue(4'b0100, gc, gg);
        chk("t3_wrap_grant", 32'(gg), 32'd2);
        for (int i = 0; i < 8; i++) begin
            step();
            req_valid = T3_TOG[i];
            @(negedge clk);
            chk("t3_toggle_ready", 32'(req_ready), 32'd0);
        end
        step();
        req_valid = 4'b0;
        wait_idle();
        issue(4'b1001, gc, gg);
        chk("t3_ptr_after_wrap", 32'(gg), 32'd3);
        wait_idle();

        // Test 4: consumer stalls 20 cycles in RESULT.
        req_data     = {4{8'h37}};
        req_budget   = 4'b0000;
        result_ready = 1'b0;
        issue(4'b0010, gc, gg);
        chk("t4_grant", 32'(gg), 32'd1);
        wait_rv(c);
        for (int i = 0; i < 20; i++) begin
            step();
            req_valid = 4'hF;
            @(negedge clk);
            chk("t4_hold_valid", 32'(result_valid), 32'd1);
            chk("t4_hold_mag", 32'(result_mag), 32'h48);
            chk("t4_hold_sign", 32'(result_sign), 32'h08);
            chk("t4_no_ready", 32'(req_ready), 32'd0);
            chk("t4_enc_reset", 32'(enc_reset), 32'd1);
        end
        step();
        result_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_valid", 32'(result_valid), 32'd1);
        step();
        @(negedge clk);
        chk("t4_done_valid", 32'(result_valid), 32'd0);
        chk("t4_next_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0;
        wait_rv(c);
        wait_idle();

        // Test 5: reset at cnt=5 in STREAM aborts the word and clears the pointer.
        req_data   = 32'hA5A5_A5A5;
        req_budget = 4'b1111;
        issue(4'b0010, gc, gg);
        chk("t5_grant", 32'(gg), 32'd1);
        repeat (6) step();
        chk("t5_streaming", 32'(enc_enable), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_result_valid", 32'(result_valid), 32'd0);
        chk("t5_req_ready", 32'(req_ready), 32'd0);
        chk("t5_enc_reset", 32'(enc_reset), 32'd1);
        chk("t5_enc_enable", 32'(enc_enable), 32'd0);
        issue(4'hF, gc, gg);
        chk("t5_grant_after_reset", 32'(gg), 32'd0);
        wait_idle();

        // Test 6: boundary words under both budgets.
        for (int i = 0; i < 8; i++) begin
            req_data   = {4{T6_W[i]}};
            req_budget = {4{T6_B[i]}};
            issue(4'(1 << (i % 4)), gc, gg);
            wait_rv(c);
            chk("t6_mag", 32'(result_mag), 32'(T6_M[i]));
            chk("t6_sign", 32'(result_sign), 32'(T6_S[i]));
            wait_idle();
        end

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
